// File: rtl/tdc_pkg.sv
// Shared types and helpers for the drift-tube TDC capture block.
// Holds the capture FSM state enum, the NO_HIT marker and the readout word packer.
// The packer works at a fixed maximum width; callers keep the low 8+CNT_W bits.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } tdc_state_t;

  // Widest time word supported by the packer.
  localparam int MAX_CNT_W = 32;

  // All-ones marks "no hit in this window". Users take the low CNT_W bits.
  localparam logic [MAX_CNT_W-1:0] NO_HIT = '1;

  // One spare top bit keeps the caller's discarded upper slice non-empty
  // even at CNT_W == MAX_CNT_W.
  localparam int PACK_W = 8 + MAX_CNT_W + 1;

  // Word layout: {channel[7:0], time[cnt_w-1:0]} right-aligned.
  function automatic logic [PACK_W-1:0] pack_word(input logic [7:0]           ch,
                                                  input logic [MAX_CNT_W-1:0] hit_t,
                                                  input int unsigned          cnt_w);
    logic [PACK_W-1:0] w;
    w = PACK_W'(hit_t) | (PACK_W'(ch) << cnt_w);
    return w;
  endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Single-clock FIFO with registered read port.
// Ports: clk/rst_n; wr_en/wr_data push; rd_en pop; rd_data/rd_valid one cycle after pop;
//        full/empty status. A pop and a push in the same cycle on a full FIFO both succeed.
module tdc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = rd_en & ~empty;
  // Pop frees the slot first, so a full FIFO still accepts a push alongside a pop.
  assign do_push = wr_en & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tube_tdc_capture.sv
// Drift-tube TDC: a scintillator coincidence opens a WINDOW-cycle timing window, the first hit
// time of every tube is latched, and the event is then serialised as (channel, time) words
// into a readout FIFO drained through rd_en.
// Ports: clk100, rst_n; scin_coin, tube_hit[NUM_CH] (asynchronous); rd_en; otube_n[8],
//        otube_r[CNT_W], rd_empty, rd_valid; busy (window or drain active); evt_drop (ignored trigger).
// Build option: define TDC_ZERO_SUPPRESS_EN to skip unhit channels during drain.
module tube_tdc_capture
  import tdc_pkg::*;
#(
  parameter int NUM_CH     = 32,
  parameter int CNT_W      = 8,
  parameter int WINDOW     = 200,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              scin_coin,
  input  logic [NUM_CH-1:0] tube_hit,
  input  logic              rd_en,
  output logic [7:0]        otube_n,
  output logic [CNT_W-1:0]  otube_r,
  output logic              rd_empty,
  output logic              rd_valid,
  output logic              busy,
  output logic              evt_drop
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int DW   = 8 + CNT_W;
  localparam logic [CNT_W-1:0] NO_HIT_T = NO_HIT[CNT_W-1:0];

  // ---------------------------------------------------------------
  // Synchronisers and rising-edge detect. Bit 0 carries the trigger,
  // bits 1..NUM_CH the tubes, so every input sees the same latency.
  // ---------------------------------------------------------------
  logic [NUM_CH:0] raw_in;
  logic [NUM_CH:0] sync1;
  logic [NUM_CH:0] sync2;
  logic [NUM_CH:0] sync3;
  logic [NUM_CH:0] rise;
  logic            coin_rise;
  logic [NUM_CH-1:0] tube_rise;

  assign raw_in = {tube_hit, scin_coin};

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise      = sync2 & ~sync3;
  assign coin_rise = rise[0];
  assign tube_rise = rise[NUM_CH:1];

  // ---------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------
  tdc_state_t       state;
  tdc_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  ch_ptr;
  logic [CNT_W-1:0] hit_time [NUM_CH];
  logic [CNT_W-1:0] cur_time;
  logic             last_ch;
  logic             arm;
  logic             push;
  logic             adv;
  logic             drop;
  logic             push_ok;
  logic             fifo_full;

  assign cur_time = hit_time[ch_ptr];
  assign last_ch  = (ch_ptr == CH_W'(NUM_CH - 1));
  // Mirrors the FIFO's own acceptance rule so ch_ptr only moves on a real push.
  assign push_ok  = ~fifo_full | (rd_en & ~rd_empty);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    push      = 1'b0;
    adv       = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (coin_rise) begin
          state_nxt = ARMED;
          arm       = 1'b1;
        end
      end
      ARMED: begin
        drop = coin_rise;
        if (cnt == CNT_W'(WINDOW - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        drop = coin_rise;
`ifdef TDC_ZERO_SUPPRESS_EN
        if (cur_time == NO_HIT_T) begin
          adv = 1'b1;
        end else begin
          push = 1'b1;
          adv  = push_ok;
        end
`else
        push = 1'b1;
        adv  = push_ok;
`endif
        if (adv && last_ch) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window counter: stops at WINDOW, which never reaches the all-ones NO_HIT value.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (arm)            cnt <= '0;
    else if (state == ARMED) cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n)              ch_ptr <= '0;
    else if (state == ARMED) ch_ptr <= '0;
    else if (adv)            ch_ptr <= last_ch ? '0 : ch_ptr + CH_W'(1);
  end

  // First-hit latch: a channel still at NO_HIT takes the current count; later hits are ignored.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) hit_time[i] <= NO_HIT_T;
    end else if (arm) begin
      for (int i = 0; i < NUM_CH; i++) hit_time[i] <= NO_HIT_T;
    end else if (state == ARMED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tube_rise[i] && (hit_time[i] == NO_HIT_T)) hit_time[i] <= cnt;
      end
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) evt_drop <= 1'b0;
    else        evt_drop <= drop;
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------
  // Word packing and readout FIFO
  // ---------------------------------------------------------------
  logic [PACK_W-1:0]    pack_wide;
  logic [DW-1:0]        push_word;
  logic [PACK_W-1:DW]   unused_pack_hi;
  logic [DW-1:0]        rd_word;

  assign pack_wide      = pack_word(8'(ch_ptr), MAX_CNT_W'(cur_time), CNT_W);
  assign push_word      = pack_wide[DW-1:0];
  assign unused_pack_hi = pack_wide[PACK_W-1:DW];

  tdc_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk100),
    .rst_n    (rst_n),
    .wr_en    (push),
    .wr_data  (push_word),
    .rd_en    (rd_en),
    .rd_data  (rd_word),
    .rd_valid (rd_valid),
    .full     (fifo_full),
    .empty    (rd_empty)
  );

  assign otube_n = rd_word[DW-1:CNT_W];
  assign otube_r = rd_word[CNT_W-1:0];

endmodule

// File: tb/tb_tube_tdc_capture.sv
module tb_tube_tdc_capture;

  localparam int NUM_CH     = 32;
  localparam int CNT_W      = 8;
  localparam int WINDOW     = 200;
  localparam int FIFO_DEPTH = 16;
  localparam int NOHIT_I    = 255;

  logic              clk100 = 1'b0;
  logic              rst_n;
  logic              scin_coin;
  logic [NUM_CH-1:0] tube_hit;
  logic              rd_en;
  logic [7:0]        otube_n;
  logic [CNT_W-1:0]  otube_r;
  logic              rd_empty;
  logic              rd_valid;
  logic              busy;
  logic              evt_drop;

  always #5 clk100 = ~clk100;

  tube_tdc_capture #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WINDOW(WINDOW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk100(clk100), .rst_n(rst_n), .scin_coin(scin_coin), .tube_hit(tube_hit),
    .rd_en(rd_en), .otube_n(otube_n), .otube_r(otube_r), .rd_empty(rd_empty),
    .rd_valid(rd_valid), .busy(busy), .evt_drop(evt_drop)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------
  // Reference model: event = list of (channel, first-hit offset) built
  // at window end, moved one entry per cycle into a bounded queue.
  // ---------------------------------------------------------------
  typedef struct { int ch; int t; } word_t;

  word_t          mfifo[$];
  word_t          pend[$];
  int             mode = 0;       // 0 idle, 1 window open, 2 draining
  int             age  = 0;
  int             mtime[NUM_CH];
  logic [NUM_CH:0] xh1 = '0, xh2 = '0, xh3 = '0;
  logic           m_valid = 1'b0;
  logic           m_drop  = 1'b0;
  logic [7:0]     m_n = '0;
  logic [CNT_W-1:0] m_r = '0;

  always @(posedge clk100 or negedge rst_n) begin : model_p
    logic [NUM_CH:0] det;
    word_t w;
    bit skip;
    if (!rst_n) begin
      mfifo.delete(); pend.delete();
      mode = 0; age = 0;
      xh1 = '0; xh2 = '0; xh3 = '0;
      m_valid = 1'b0; m_drop = 1'b0; m_n = '0; m_r = '0;
    end else begin
      // Input rise seen two samples ago becomes visible to the capture logic now.
      det = xh2 & ~xh3;
      xh3 = xh2; xh2 = xh1; xh1 = {tube_hit, scin_coin};
      m_valid = 1'b0;
      m_drop  = 1'b0;
      if (rd_en && mfifo.size() > 0) begin
        w = mfifo.pop_front();
        m_valid = 1'b1; m_n = 8'(w.ch); m_r = CNT_W'(w.t);
      end
      case (mode)
        0: if (det[0]) begin
             mode = 1; age = 0;
             foreach (mtime[i]) mtime[i] = NOHIT_I;
           end
        1: begin
             m_drop = det[0];
             for (int i = 0; i < NUM_CH; i++)
               if (det[i+1] && mtime[i] == NOHIT_I) mtime[i] = age;
             if (age == WINDOW - 1) begin
               mode = 2;
               pend.delete();
               for (int i = 0; i < NUM_CH; i++) pend.push_back('{ch: i, t: mtime[i]});
             end else age++;
           end
        default: begin
             m_drop = det[0];
             skip = 1'b0;
`ifdef TDC_ZERO_SUPPRESS_EN
             skip = (pend[0].t == NOHIT_I);
`endif
             if (skip) void'(pend.pop_front());
             else if (mfifo.size() < FIFO_DEPTH) mfifo.push_back(pend.pop_front());
             if (pend.size() == 0) mode = 0;
           end
      endcase
    end
  end

  // Per-cycle comparison and readout capture, away from the active edge.
  word_t got[$];
  int    drop_cnt = 0;

  always @(negedge clk100) begin
    if (rst_n === 1'b1) begin
      chk("rd_empty", rd_empty, (mfifo.size() == 0));
      chk("busy",     busy,     (mode != 0));
      chk("evt_drop", evt_drop, m_drop);
      chk("rd_valid", rd_valid, m_valid);
      chk("otube_n",  otube_n,  m_n);
      chk("otube_r",  otube_r,  m_r);
      if (rd_valid) got.push_back('{ch: int'(otube_n), t: int'(otube_r)});
      if (evt_drop) drop_cnt++;
    end
  end

  // ---------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------
  typedef struct { int ch; int st; int len; } pulse_t;   // ch < 0 means trigger
  pulse_t pl[$];

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk100); #2; end
  endtask

  task automatic play(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic coin;
      logic [NUM_CH-1:0] th;
      coin = 1'b0; th = '0;
      foreach (pl[k])
        if (c >= pl[k].st && c < pl[k].st + pl[k].len) begin
          if (pl[k].ch < 0) coin = 1'b1;
          else th[pl[k].ch] = 1'b1;
        end
      scin_coin = coin; tube_hit = th;
      tick(1);
    end
    scin_coin = 1'b0; tube_hit = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int quiet;
    quiet = 0;
    rd_en = 1'b1;
    for (int c = 0; c < budget && quiet < 3; c++) begin
      tick(1);
      if (!busy && rd_empty) quiet++; else quiet = 0;
    end
    chk(name, (quiet >= 3), 1);
    rd_en = 1'b0;
    tick(2);
  endtask

  function automatic int got_ch(input int k);
    return (k < got.size()) ? got[k].ch : -1;
  endfunction

  function automatic int got_t(input int k);
    return (k < got.size()) ? got[k].t : -1;
  endfunction

  // Full-event layout: channel order 0..N-1, and NO_HIT on every channel except ha/hb.
  function automatic int layout_bad(input int ha, input int hb);
    int bad;
    bad = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i].ch != i) bad++;
      else if (i != ha && i != hb && got[i].t != NOHIT_I) bad++;
    end
    return bad;
  endfunction

  task automatic new_test();
    got.delete(); pl.delete(); drop_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; scin_coin = 1'b0; tube_hit = '0; rd_en = 1'b0;
    #1;
    chk("reset_rd_empty", rd_empty, 1);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_busy",     busy,     0);
    chk("reset_evt_drop", evt_drop, 0);
    chk("reset_otube_n",  otube_n,  0);
    chk("reset_otube_r",  otube_r,  0);
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Hits on ch3 and ch17 at counts 10 and 57.
    new_test();
    pl.push_back('{-1, 0, 3}); pl.push_back('{3, 11, 2}); pl.push_back('{17, 58, 2});
    play(60);
    drain("t1_drain", 800);
`ifdef TDC_ZERO_SUPPRESS_EN
    chk("t1_count", got.size(), 2);
    chk("t1_w0_ch", got_ch(0), 3);  chk("t1_w0_t", got_t(0), 10);
    chk("t1_w1_ch", got_ch(1), 17); chk("t1_w1_t", got_t(1), 57);
`else
    chk("t1_count", got.size(), NUM_CH);
    chk("t1_ch3_t", got_t(3), 10);
    chk("t1_ch17_t", got_t(17), 57);
    chk("t1_layout", layout_bad(3, 17), 0);
`endif

    // ch5 pulses at counts 20 and 40: only the first counts.
    new_test();
    pl.push_back('{-1, 0, 3}); pl.push_back('{5, 21, 3}); pl.push_back('{5, 41, 3});
    play(50);
    drain("t2_drain", 800);
`ifdef TDC_ZERO_SUPPRESS_EN
    chk("t2_count", got.size(), 1);
    chk("t2_ch", got_ch(0), 5); chk("t2_t", got_t(0), 20);
`else
    chk("t2_count", got.size(), NUM_CH);
    chk("t2_ch5_t", got_t(5), 20);
    chk("t2_layout", layout_bad(5, -1), 0);
`endif

    // Second trigger while the window is open is dropped, no second event follows.
    new_test();
    pl.push_back('{-1, 0, 3}); pl.push_back('{-1, 100, 3}); pl.push_back('{9, 31, 2});
    play(110);
    drain("t3_drain", 800);
    rd_en = 1'b1; tick(300); rd_en = 1'b0; tick(2);
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_busy_after", busy, 0);
`ifdef TDC_ZERO_SUPPRESS_EN
    chk("t3_count", got.size(), 1);
    chk("t3_t", got_t(0), 30);
`else
    chk("t3_count", got.size(), NUM_CH);
    chk("t3_ch9_t", got_t(9), 30);
`endif

    // Readout held off: drain stalls on a full FIFO, resumes one word at a time.
    new_test();
    pl.push_back('{-1, 0, 3}); pl.push_back('{0, 5, 2}); pl.push_back('{31, 150, 2});
    play(260);
`ifndef TDC_ZERO_SUPPRESS_EN
    chk("t4_stall_busy", busy, 1);
    chk("t4_stall_nonempty", rd_empty, 0);
    tick(100);
    chk("t4_stall_holds", busy, 1);
    rd_en = 1'b1; tick(1); rd_en = 1'b0; tick(5);
    chk("t4_one_word", got.size(), 1);
    chk("t4_still_stalled", busy, 1);
`endif
    drain("t4_drain", 800);
`ifdef TDC_ZERO_SUPPRESS_EN
    chk("t4_count", got.size(), 2);
    chk("t4_w0_ch", got_ch(0), 0);  chk("t4_w0_t", got_t(0), 4);
    chk("t4_w1_ch", got_ch(1), 31); chk("t4_w1_t", got_t(1), 149);
`else
    chk("t4_count", got.size(), NUM_CH);
    chk("t4_ch0_t", got_t(0), 4);
    chk("t4_ch31_t", got_t(31), 149);
    chk("t4_layout", layout_bad(0, 31), 0);
`endif

    // Reset during drain, then a clean event.
    new_test();
    pl.push_back('{-1, 0, 3}); pl.push_back('{4, 12, 2});
    play(250);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_empty", rd_empty, 1);
    chk("t5_rst_busy",  busy,     0);
    chk("t5_rst_valid", rd_valid, 0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    new_test();
    pl.push_back('{-1, 0, 3}); pl.push_back('{7, 31, 2});
    play(40);
    drain("t5_drain", 800);
`ifdef TDC_ZERO_SUPPRESS_EN
    chk("t5_count", got.size(), 1);
    chk("t5_t", got_t(0), 30);
`else
    chk("t5_count", got.size(), NUM_CH);
    chk("t5_ch7_t", got_t(7), 30);
    chk("t5_layout", layout_bad(7, -1), 0);
`endif

    // Random traffic: triggers, tube pulses, bursty reads with long hold-off periods.
    new_test();
    for (int c = 0; c < 5000; c++) begin
      rd_en = ((c % 1000) < 400) ? 1'b0 : ($urandom_range(0, 2) != 0);
      scin_coin = scin_coin ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NUM_CH; i++)
        tube_hit[i] = tube_hit[i] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 79) == 0);
      tick(1);
    end
    scin_coin = 1'b0; tube_hit = '0;
    drain("rand_drain", 2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
